// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: format select, opcode constants and field positions.
// The instruction field parser uses the same field positions.
package mips_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned JADDR_W = 26;
   localparam int unsigned CNT_W   = 16;

   // Field bit positions within the 32-bit instruction word
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 26;
   localparam int unsigned RS_MSB     = 25;
   localparam int unsigned RS_LSB     = 21;
   localparam int unsigned RT_MSB     = 20;
   localparam int unsigned RT_LSB     = 16;
   localparam int unsigned RD_MSB     = 15;
   localparam int unsigned RD_LSB     = 11;
   localparam int unsigned SHAMT_MSB  = 10;
   localparam int unsigned SHAMT_LSB  = 6;
   localparam int unsigned FUNCT_MSB  = 5;
   localparam int unsigned FUNCT_LSB  = 0;
   localparam int unsigned IMM_MSB    = 15;
   localparam int unsigned IMM_LSB    = 0;
   localparam int unsigned JADDR_MSB  = 25;
   localparam int unsigned JADDR_LSB  = 0;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;

   typedef enum logic [1:0] {
      FMT_R    = 2'd0,
      FMT_I    = 2'd1,
      FMT_J    = 2'd2,
      FMT_RSVD = 2'd3
   } fmt_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } enc_state_e;

   // Opcodes that an I-format bundle may not carry
   function automatic logic is_i_reserved(input logic [OP_W-1:0] op);
      return (op == OP_RTYPE) || (op == OP_J) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/ins_field_pack.sv
// Combinational packer: builds the instruction word for the selected format
// and flags bundles whose format/opcode combination is not encodable.
module ins_field_pack
   import mips_pkg::*;
(
   input  fmt_e                 fmt,
   input  logic [OP_W-1:0]      opcode,
   input  logic [REG_W-1:0]     rs,
   input  logic [REG_W-1:0]     rt,
   input  logic [REG_W-1:0]     rd,
   input  logic [REG_W-1:0]     shamt,
   input  logic [FUNCT_W-1:0]   funct,
   input  logic [IMM_W-1:0]     imm,
   input  logic [JADDR_W-1:0]   address,
   output logic [INSTR_W-1:0]   word,
   output logic                 legal
);

   always_comb begin
      word  = '0;
      legal = 1'b0;
      case (fmt)
         FMT_R: begin
            // R-type opcode is forced; the opcode input is ignored
            word[OPCODE_MSB:OPCODE_LSB] = OP_RTYPE;
            word[RS_MSB:RS_LSB]         = rs;
            word[RT_MSB:RT_LSB]         = rt;
            word[RD_MSB:RD_LSB]         = rd;
            word[SHAMT_MSB:SHAMT_LSB]   = shamt;
            word[FUNCT_MSB:FUNCT_LSB]   = funct;
            legal                       = 1'b1;
         end
         FMT_I: begin
            word[OPCODE_MSB:OPCODE_LSB] = opcode;
            word[RS_MSB:RS_LSB]         = rs;
            word[RT_MSB:RT_LSB]         = rt;
            word[IMM_MSB:IMM_LSB]       = imm;
            legal                       = !is_i_reserved(opcode);
         end
         FMT_J: begin
            word[OPCODE_MSB:OPCODE_LSB] = opcode;
            word[JADDR_MSB:JADDR_LSB]   = address;
            legal                       = (opcode == OP_J) || (opcode == OP_JAL);
         end
         default: begin
            word  = '0;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ins_encoder.sv
// Program-loader encoder: accepts decoded MIPS fields, packs them into a word and
// emits it with its instruction-memory byte address; halts on an illegal bundle.
module ins_encoder
   import mips_pkg::*;
#(
   parameter int unsigned        ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           fmt,
   input  logic [OP_W-1:0]      opcode,
   input  logic [REG_W-1:0]     rs,
   input  logic [REG_W-1:0]     rt,
   input  logic [REG_W-1:0]     rd,
   input  logic [REG_W-1:0]     shamt,
   input  logic [FUNCT_W-1:0]   funct,
   input  logic [IMM_W-1:0]     imm,
   input  logic [JADDR_W-1:0]   address,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INSTR_W-1:0]   instruction,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [CNT_W-1:0]     count,
   output logic                 err
);

   enc_state_e            r_state;
   logic                  r_out_valid;
   logic [INSTR_W-1:0]    r_instruction;
   logic [ADDR_W-1:0]     r_wr_addr;
   logic [CNT_W-1:0]      r_count;
   logic                  r_err;

   logic [INSTR_W-1:0]    w_word;
   logic                  w_legal;
   logic                  w_in_hs;
   logic                  w_out_hs;
   logic [CNT_W-1:0]      w_count_nxt;
   logic [ADDR_W-1:0]     w_addr_nxt;

   ins_field_pack u_pack (
      .fmt     (fmt_e'(fmt)),
      .opcode  (opcode),
      .rs      (rs),
      .rt      (rt),
      .rd      (rd),
      .shamt   (shamt),
      .funct   (funct),
      .imm     (imm),
      .address (address),
      .word    (w_word),
      .legal   (w_legal)
   );

   // Single-entry output register: refill allowed in the same cycle it drains
   assign in_ready    = (r_state == ST_RUN) && (!r_out_valid || out_ready);
   assign w_in_hs     = in_valid && in_ready;
   assign w_out_hs    = r_out_valid && out_ready;
   assign w_count_nxt = r_count + CNT_W'(1);
   // Address tracks BASE_ADDR + 4*count, so it follows the 16-bit count wrap
   assign w_addr_nxt  = BASE_ADDR + ADDR_W'({w_count_nxt, 2'b00});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_RUN;
         r_out_valid   <= 1'b0;
         r_instruction <= '0;
         r_wr_addr     <= BASE_ADDR;
         r_count       <= '0;
         r_err         <= 1'b0;
      end else if (clear) begin
         r_state     <= ST_RUN;
         r_out_valid <= 1'b0;
         r_wr_addr   <= BASE_ADDR;
         r_count     <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_count     <= w_count_nxt;
            r_wr_addr   <= w_addr_nxt;
         end
         case (r_state)
            ST_RUN: begin
               if (w_in_hs) begin
                  if (w_legal) begin
                     r_out_valid   <= 1'b1;
                     r_instruction <= w_word;
                  end else begin
                     r_state <= ST_HALT;
                     r_err   <= 1'b1;
                  end
               end
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            default: begin
               r_state <= ST_HALT;
            end
         endcase
      end
   end

   assign out_valid   = r_out_valid;
   assign instruction = r_instruction;
   assign wr_addr     = r_wr_addr;
   assign count       = r_count;
   assign err         = r_err;

endmodule

// File: tb/tb_ins_encoder.sv
// Directed self-checking bench for ins_encoder with a non-zero base address.
module tb_ins_encoder;

   localparam int unsigned ADDR_W = 32;
   localparam logic [31:0] BASE   = 32'h0040_0000;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  fmt;
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [25:0] address;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instruction;
   logic [31:0] wr_addr;
   logic [15:0] count;
   logic        err;

   int n_pass;
   int n_total;

   ins_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .fmt         (fmt),
      .opcode      (opcode),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .shamt       (shamt),
      .funct       (funct),
      .imm         (imm),
      .address     (address),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .instruction (instruction),
      .wr_addr     (wr_addr),
      .count       (count),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ad);
      fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; address = ad;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      drive(2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
      repeat (2) @(negedge clk);
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b exp 0", out_valid); else n_pass++;
      n_total++; if (instruction !== 32'h0) $display("FAIL reset_instr got %08h exp 00000000", instruction); else n_pass++;
      n_total++; if (wr_addr !== BASE) $display("FAIL reset_wr_addr got %08h exp %08h", wr_addr, BASE); else n_pass++;
      n_total++; if (count !== 16'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL reset_err got %0b exp 0", err); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", in_ready); else n_pass++;
   endtask

   task automatic test_r_type();
      out_ready = 1'b0;
      drive(2'd0, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_total++; if (out_valid !== 1'b1) $display("FAIL r_out_valid got %0b exp 1", out_valid); else n_pass++;
      n_total++; if (instruction !== 32'h00221820) $display("FAIL r_instr got %08h exp 00221820", instruction); else n_pass++;
      n_total++; if (wr_addr !== BASE) $display("FAIL r_wr_addr got %08h exp %08h", wr_addr, BASE); else n_pass++;
      n_total++; if (count !== 16'd0) $display("FAIL r_count_pre got %0d exp 0", count); else n_pass++;
      out_ready = 1'b1;
      @(negedge clk);
      n_total++; if (out_valid !== 1'b0) $display("FAIL r_drain_valid got %0b exp 0", out_valid); else n_pass++;
      n_total++; if (count !== 16'd1) $display("FAIL r_count got %0d exp 1", count); else n_pass++;
      n_total++; if (wr_addr !== BASE + 32'd4) $display("FAIL r_next_addr got %08h exp %08h", wr_addr, BASE + 32'd4); else n_pass++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      drive(2'd1, 6'h08, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0005, 26'h0);
      in_valid = 1'b1;
      @(negedge clk);
      n_total++; if (instruction !== 32'h20080005) $display("FAIL b2b_addi got %08h exp 20080005", instruction); else n_pass++;
      n_total++; if (wr_addr !== BASE + 32'd4) $display("FAIL b2b_addi_addr got %08h exp %08h", wr_addr, BASE + 32'd4); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got %0b exp 1", in_ready); else n_pass++;
      drive(2'd1, 6'h23, 5'd29, 5'd9, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0);
      @(negedge clk);
      in_valid = 1'b0;
      n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_lw_valid got %0b exp 1", out_valid); else n_pass++;
      n_total++; if (instruction !== 32'h8FA90004) $display("FAIL b2b_lw got %08h exp 8FA90004", instruction); else n_pass++;
      n_total++; if (wr_addr !== BASE + 32'd8) $display("FAIL b2b_lw_addr got %08h exp %08h", wr_addr, BASE + 32'd8); else n_pass++;
      n_total++; if (count !== 16'd2) $display("FAIL b2b_count got %0d exp 2", count); else n_pass++;
      @(negedge clk);
      n_total++; if (count !== 16'd3) $display("FAIL b2b_count_end got %0d exp 3", count); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_idle got %0b exp 0", out_valid); else n_pass++;
   endtask

   task automatic test_j_backpressure();
      out_ready = 1'b0;
      drive(2'd2, 6'h02, 5'd7, 5'd7, 5'd7, 5'd7, 6'h7, 16'h1234, 26'h0100000);
      in_valid = 1'b1;
      @(negedge clk);
      n_total++; if (instruction !== 32'h08100000) $display("FAIL j_instr got %08h exp 08100000", instruction); else n_pass++;
      n_total++; if (wr_addr !== BASE + 32'd12) $display("FAIL j_addr got %08h exp %08h", wr_addr, BASE + 32'd12); else n_pass++;
      // A competing bundle waits while the output is stalled
      drive(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %0b exp 0", i, in_ready); else n_pass++;
         n_total++; if (instruction !== 32'h08100000) $display("FAIL bp_instr[%0d] got %08h exp 08100000", i, instruction); else n_pass++;
         n_total++; if (wr_addr !== BASE + 32'd12) $display("FAIL bp_addr[%0d] got %08h exp %08h", i, wr_addr, BASE + 32'd12); else n_pass++;
         n_total++; if (count !== 16'd3) $display("FAIL bp_count[%0d] got %0d exp 3", i, count); else n_pass++;
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_total++; if (instruction !== 32'h20080005) $display("FAIL bp_replace got %08h exp 20080005", instruction); else n_pass++;
      n_total++; if (count !== 16'd4) $display("FAIL bp_count_once got %0d exp 4", count); else n_pass++;
      n_total++; if (wr_addr !== BASE + 32'd16) $display("FAIL bp_next_addr got %08h exp %08h", wr_addr, BASE + 32'd16); else n_pass++;
      @(negedge clk);
      n_total++; if (count !== 16'd5) $display("FAIL bp_count_end got %0d exp 5", count); else n_pass++;
   endtask

   task automatic test_illegal_clear();
      out_ready = 1'b1;
      drive(2'd2, 6'h04, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010);
      in_valid = 1'b1;
      @(negedge clk);
      drive(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
      n_total++; if (err !== 1'b1) $display("FAIL illj_err got %0b exp 1", err); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL illj_valid got %0b exp 0", out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL illj_in_ready got %0b exp 0", in_ready); else n_pass++;
      @(negedge clk);
      in_valid = 1'b0;
      n_total++; if (out_valid !== 1'b0) $display("FAIL halt_valid got %0b exp 0", out_valid); else n_pass++;
      n_total++; if (count !== 16'd5) $display("FAIL halt_count got %0d exp 5", count); else n_pass++;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_total++; if (err !== 1'b0) $display("FAIL clr_err got %0b exp 0", err); else n_pass++;
      n_total++; if (count !== 16'd0) $display("FAIL clr_count got %0d exp 0", count); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL clr_in_ready got %0b exp 1", in_ready); else n_pass++;
      n_total++; if (wr_addr !== BASE) $display("FAIL clr_addr got %08h exp %08h", wr_addr, BASE); else n_pass++;
      // Illegal I (opcode 0) halts too
      drive(2'd1, 6'h00, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1, 26'h0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_total++; if (err !== 1'b1) $display("FAIL illi_err got %0b exp 1", err); else n_pass++;
      clear = 1'b1;
      @(negedge clk);
      // Reserved format halts
      clear = 1'b0;
      drive(2'd3, 6'h08, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1, 26'h0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_total++; if (err !== 1'b1) $display("FAIL rsvd_err got %0b exp 1", err); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rsvd_valid got %0b exp 0", out_valid); else n_pass++;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      // Clear wins over a pending word and an input handshake in the same cycle
      out_ready = 1'b0;
      drive(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000040);
      in_valid = 1'b1;
      @(negedge clk);
      n_total++; if (instruction !== 32'h0C000040) $display("FAIL jal_instr got %08h exp 0C000040", instruction); else n_pass++;
      out_ready = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      in_valid = 1'b0;
      n_total++; if (out_valid !== 1'b0) $display("FAIL clr_drop_valid got %0b exp 0", out_valid); else n_pass++;
      n_total++; if (count !== 16'd0) $display("FAIL clr_drop_count got %0d exp 0", count); else n_pass++;
      drive(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_total++; if (wr_addr !== BASE) $display("FAIL clr_first_addr got %08h exp %08h", wr_addr, BASE); else n_pass++;
      n_total++; if (out_valid !== 1'b1) $display("FAIL clr_first_valid got %0b exp 1", out_valid); else n_pass++;
      @(negedge clk);
      n_total++; if (count !== 16'd1) $display("FAIL clr_first_count got %0d exp 1", count); else n_pass++;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_total++; if (out_valid !== 1'b1) $display("FAIL ar_pre_valid got %0b exp 1", out_valid); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL ar_valid_drop got %0b exp 0", out_valid); else n_pass++;
      n_total++; if (count !== 16'd0) $display("FAIL ar_count got %0d exp 0", count); else n_pass++;
      n_total++; if (instruction !== 32'h0) $display("FAIL ar_instr got %08h exp 00000000", instruction); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_total++; if (out_valid !== 1'b0) $display("FAIL ar_no_partial got %0b exp 0", out_valid); else n_pass++;
      out_ready = 1'b1;
      drive(2'd1, 6'h23, 5'd29, 5'd9, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_total++; if (wr_addr !== BASE) $display("FAIL ar_first_addr got %08h exp %08h", wr_addr, BASE); else n_pass++;
      n_total++; if (instruction !== 32'h8FA90004) $display("FAIL ar_first_instr got %08h exp 8FA90004", instruction); else n_pass++;
      @(negedge clk);
      n_total++; if (count !== 16'd1) $display("FAIL ar_count_end got %0d exp 1", count); else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_r_type();
      test_back_to_back();
      test_j_backpressure();
      test_illegal_clear();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
